// File: rtl/hazard_forward_unit.sv
// Operand forwarding select, load-use bubble insertion and memory-wait freeze for an in-order pipeline.
// Defining HFU_STATS_EN adds saturating stall/freeze cycle counters as output ports.
module hazard_forward_unit #(
    parameter int FWD_STAGES = 3,
    parameter int REG_W      = 5,
    parameter int LU_LAT     = 1
) (
    input  logic                        CLK,
    input  logic                        nRST,
    input  logic [REG_W-1:0]            id_rs,
    input  logic [REG_W-1:0]            id_rt,
    input  logic                        id_useRs,
    input  logic                        id_useRt,
    input  logic [FWD_STAGES-1:0]       stage_regWrite,
    input  logic [FWD_STAGES-1:0]       stage_load,
    input  logic [FWD_STAGES*REG_W-1:0] stage_dest,
    input  logic                        mem_busy,
    output logic [2:0]                  forwardA,
    output logic [2:0]                  forwardB,
    output logic                        stall,
    output logic                        flush_ex,
    output logic                        freeze,
    output logic [1:0]                  fsm_state
`ifdef HFU_STATS_EN
    ,
    output logic [31:0]                 lu_stall_cnt,
    output logic [31:0]                 freeze_cnt
`endif
);

    typedef enum logic [1:0] {RUN = 2'd0, LU_STALL = 2'd1, FREEZE = 2'd2} state_t;

    state_t     state, next_state, saved, next_saved, eff_state;
    logic [1:0] cnt, next_cnt;
    logic [2:0] hold_a, hold_b, next_hold_a, next_hold_b;
    logic [FWD_STAGES-1:0] match_a, match_b;
    logic [2:0] fwd_a, fwd_b, fa_i, fb_i;
    logic [1:0] bub_a, bub_b, bub;
    logic       stall_i, flush_i, freeze_i;

    // Lowest-indexed matching stage whose data is already available.
    function automatic logic [2:0] fwd_sel(input logic [FWD_STAGES-1:0] m,
                                           input logic [FWD_STAGES-1:0] ld);
        logic [2:0] r;
        r = 3'd0;
        for (int k = FWD_STAGES - 1; k >= 0; k--)
            if (m[k] && (!ld[k] || k >= LU_LAT)) r = 3'(k + 1);
        return r;
    endfunction

    // Bubbles needed when the youngest match is a load still inside the load-use window.
    function automatic logic [1:0] bubbles(input logic [FWD_STAGES-1:0] m,
                                           input logic [FWD_STAGES-1:0] ld);
        logic [1:0] r;
        r = 2'd0;
        for (int k = FWD_STAGES - 1; k >= 0; k--)
            if (m[k]) r = (ld[k] && k < LU_LAT) ? 2'(LU_LAT - k) : 2'd0;
        return r;
    endfunction

    always_comb begin
        for (int k = 0; k < FWD_STAGES; k++) begin
            match_a[k] = stage_regWrite[k] && (stage_dest[k*REG_W +: REG_W] != '0)
                         && (stage_dest[k*REG_W +: REG_W] == id_rs) && id_useRs;
            match_b[k] = stage_regWrite[k] && (stage_dest[k*REG_W +: REG_W] != '0)
                         && (stage_dest[k*REG_W +: REG_W] == id_rt) && id_useRt;
        end
    end

    assign fwd_a = fwd_sel(match_a, stage_load);
    assign fwd_b = fwd_sel(match_b, stage_load);
    assign bub_a = bubbles(match_a, stage_load);
    assign bub_b = bubbles(match_b, stage_load);
    assign bub   = (bub_a > bub_b) ? bub_a : bub_b;

    // The cycle memory becomes ready again is handled as the state that was interrupted.
    assign eff_state = (state == FREEZE && !mem_busy) ? saved : state;

    always_comb begin
        next_state  = state;
        next_saved  = saved;
        next_cnt    = cnt;
        next_hold_a = hold_a;
        next_hold_b = hold_b;
        fa_i        = fwd_a;
        fb_i        = fwd_b;
        stall_i     = 1'b0;
        flush_i     = 1'b0;
        freeze_i    = 1'b0;
        case (eff_state)
            RUN: begin
                next_state = RUN;
                if (mem_busy) begin
                    freeze_i    = 1'b1;
                    next_hold_a = fwd_a;
                    next_hold_b = fwd_b;
                    next_saved  = RUN;
                    next_state  = FREEZE;
                end else if (bub != 2'd0) begin
                    stall_i = 1'b1;
                    flush_i = 1'b1;
                    if (bub > 2'd1) begin
                        next_cnt   = bub - 2'd1;
                        next_state = LU_STALL;
                    end
                end
            end
            LU_STALL: begin
                if (mem_busy) begin
                    freeze_i    = 1'b1;
                    next_hold_a = fwd_a;
                    next_hold_b = fwd_b;
                    next_saved  = LU_STALL;
                    next_state  = FREEZE;
                end else begin
                    stall_i    = 1'b1;
                    flush_i    = 1'b1;
                    next_cnt   = cnt - 2'd1;
                    next_state = (cnt == 2'd1) ? RUN : LU_STALL;
                end
            end
            default: begin
                freeze_i   = 1'b1;
                fa_i       = hold_a;
                fb_i       = hold_b;
                next_state = FREEZE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state  <= RUN;
            saved  <= RUN;
            cnt    <= 2'd0;
            hold_a <= 3'd0;
            hold_b <= 3'd0;
        end else begin
            state  <= next_state;
            saved  <= next_saved;
            cnt    <= next_cnt;
            hold_a <= next_hold_a;
            hold_b <= next_hold_b;
        end
    end

    // Outputs are forced low while reset is held so an abandoned freeze/stall releases at once.
    assign forwardA  = nRST ? fa_i : 3'd0;
    assign forwardB  = nRST ? fb_i : 3'd0;
    assign stall     = nRST & stall_i;
    assign flush_ex  = nRST & flush_i;
    assign freeze    = nRST & freeze_i;
    assign fsm_state = state;

`ifdef HFU_STATS_EN
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            lu_stall_cnt <= 32'd0;
            freeze_cnt   <= 32'd0;
        end else begin
            if (stall && lu_stall_cnt != 32'hFFFF_FFFF) lu_stall_cnt <= lu_stall_cnt + 32'd1;
            if (freeze && freeze_cnt != 32'hFFFF_FFFF) freeze_cnt <= freeze_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed-vector bench for hazard_forward_unit; two instances (LU_LAT=1 and LU_LAT=2) share stimulus.
// Expected outputs are queued per cycle by the driver and checked by a negedge monitor.
module tb_hazard_forward_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  id_rs = '0, id_rt = '0;
  logic        id_use_rs = 1'b0, id_use_rt = 1'b0;
  logic [2:0]  stage_rw = '0, stage_ld = '0;
  logic [14:0] stage_dest = '0;
  logic        mem_busy = 1'b0;

  logic [2:0]  fa1, fb1, fa2, fb2;
  logic        stall1, flush1, freeze1, stall2, flush2, freeze2;
  logic [1:0]  st1, st2;
`ifdef HFU_STATS_EN
  logic [31:0] lsc1, fzc1, lsc2, fzc2;
`endif

  logic [8:0] exp1_q[$];
  logic [8:0] exp2_q[$];
  int n_cmp = 0;
  int n_err = 0;
  int mon_idx = 0;

  always #5 clk = ~clk;

  hazard_forward_unit #(.FWD_STAGES(3), .REG_W(5), .LU_LAT(1)) dut1 (
    .CLK(clk), .nRST(rst_n), .id_rs(id_rs), .id_rt(id_rt),
    .id_useRs(id_use_rs), .id_useRt(id_use_rt),
    .stage_regWrite(stage_rw), .stage_load(stage_ld), .stage_dest(stage_dest),
    .mem_busy(mem_busy), .forwardA(fa1), .forwardB(fb1),
    .stall(stall1), .flush_ex(flush1), .freeze(freeze1), .fsm_state(st1)
`ifdef HFU_STATS_EN
    , .lu_stall_cnt(lsc1), .freeze_cnt(fzc1)
`endif
  );

  hazard_forward_unit #(.FWD_STAGES(3), .REG_W(5), .LU_LAT(2)) dut2 (
    .CLK(clk), .nRST(rst_n), .id_rs(id_rs), .id_rt(id_rt),
    .id_useRs(id_use_rs), .id_useRt(id_use_rt),
    .stage_regWrite(stage_rw), .stage_load(stage_ld), .stage_dest(stage_dest),
    .mem_busy(mem_busy), .forwardA(fa2), .forwardB(fb2),
    .stall(stall2), .flush_ex(flush2), .freeze(freeze2), .fsm_state(st2)
`ifdef HFU_STATS_EN
    , .lu_stall_cnt(lsc2), .freeze_cnt(fzc2)
`endif
  );

  function automatic logic [8:0] pk(input logic [2:0] fa, input logic [2:0] fb,
                                    input logic s, input logic f, input logic z);
    return {fa, fb, s, f, z};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One cycle of stimulus: rst=1 holds/asserts reset during this cycle.
  task automatic step(input logic rst, input logic busy,
                      input logic [4:0] rs, input logic urs,
                      input logic [4:0] rt, input logic urt,
                      input logic [2:0] rw, input logic [2:0] ld,
                      input logic [4:0] d0, input logic [4:0] d1, input logic [4:0] d2,
                      input logic [8:0] e1, input logic [8:0] e2);
    @(posedge clk);
    #1;
    id_rs = rs; id_use_rs = urs;
    id_rt = rt; id_use_rt = urt;
    stage_rw = rw; stage_ld = ld;
    stage_dest = {d2, d1, d0};
    mem_busy = busy;
    rst_n = ~rst;
    exp1_q.push_back(e1);
    exp2_q.push_back(e2);
  endtask

  // Monitor: outputs are presented every cycle; pop one expectation per DUT per cycle.
  always @(negedge clk) begin
    if (exp1_q.size() > 0) begin
      logic [8:0] e;
      e = exp1_q.pop_front();
      chk($sformatf("dut1 v%0d", mon_idx), {23'd0, fa1, fb1, stall1, flush1, freeze1}, {23'd0, e});
    end
    if (exp2_q.size() > 0) begin
      logic [8:0] e;
      e = exp2_q.pop_front();
      chk($sformatf("dut2 v%0d", mon_idx), {23'd0, fa2, fb2, stall2, flush2, freeze2}, {23'd0, e});
      mon_idx++;
    end
  end

  initial begin
    logic [8:0] z;
    z = 9'd0;
    // Reset: outputs held low even with hazard and busy present.
    step(1, 0, 0,0, 0,0, 3'b000,3'b000, 0,0,0, z, z);
    step(1, 1, 5,1, 5,1, 3'b001,3'b001, 5,0,0, z, z);
`ifdef HFU_STATS_EN
    @(negedge clk);
    chk("rst lsc1", lsc1, 0); chk("rst fzc1", fzc1, 0);
    chk("rst lsc2", lsc2, 0); chk("rst fzc2", fzc2, 0);
`endif
    // Youngest match wins; use flag gates matching.
    step(0, 0, 5,1, 0,0, 3'b011,3'b000, 5,5,0, pk(1,0,0,0,0), pk(1,0,0,0,0));
    step(0, 0, 5,0, 0,0, 3'b011,3'b000, 5,5,0, z, z);
    // r0 destination never forwards.
    step(0, 0, 0,0, 0,1, 3'b001,3'b000, 0,0,0, z, z);
    step(0, 0, 9,1, 9,1, 3'b010,3'b000, 0,9,0, pk(2,2,0,0,0), pk(2,2,0,0,0));
    step(0, 0, 0,0, 12,1, 3'b100,3'b100, 0,0,12, pk(0,3,0,0,0), pk(0,3,0,0,0));
    // Load in stage0 to r3 on rt.
    step(0, 0, 0,0, 3,1, 3'b001,3'b001, 3,0,0, pk(0,0,1,1,0), pk(0,0,1,1,0));
    step(0, 0, 0,0, 3,1, 3'b010,3'b010, 0,3,0, pk(0,2,0,0,0), pk(0,0,1,1,0));
    step(0, 0, 0,0, 3,1, 3'b100,3'b100, 0,0,3, pk(0,3,0,0,0), pk(0,3,0,0,0));
    // Load to r7 on rs, then mem_busy for 4 cycles while dut2 is in LU_STALL.
    step(0, 0, 7,1, 0,0, 3'b001,3'b001, 7,0,0, pk(0,0,1,1,0), pk(0,0,1,1,0));
    step(0, 1, 7,1, 4,1, 3'b110,3'b010, 0,7,4, pk(2,3,0,0,1), pk(0,3,0,0,1));
    for (int i = 0; i < 3; i++)
      step(0, 1, 7,1, 0,0, 3'b001,3'b001, 7,0,0, pk(2,3,0,0,1), pk(0,3,0,0,1));
    step(0, 0, 7,1, 0,0, 3'b010,3'b010, 0,7,0, pk(2,0,0,0,0), pk(0,0,1,1,0));
    step(0, 0, 7,1, 0,0, 3'b100,3'b100, 0,0,7, pk(3,0,0,0,0), pk(3,0,0,0,0));
    // Hazard and busy together: freeze only; hazard resolved on release.
    step(0, 1, 0,0, 3,1, 3'b001,3'b001, 3,0,0, pk(0,0,0,0,1), pk(0,0,0,0,1));
    step(0, 0, 0,0, 3,1, 3'b001,3'b001, 3,0,0, pk(0,0,1,1,0), pk(0,0,1,1,0));
    step(0, 0, 0,0, 0,0, 3'b000,3'b000, 0,0,0, z, pk(0,0,1,1,0));
    // Stage1 load: one bubble for LU_LAT=2, forwardable for LU_LAT=1.
    step(0, 0, 6,1, 0,0, 3'b010,3'b010, 0,6,0, pk(2,0,0,0,0), pk(0,0,1,1,0));
    step(0, 0, 0,0, 0,0, 3'b000,3'b000, 0,0,0, z, z);
    // Stage0 load shadows stage1 ALU result: stall, forward points at stage1.
    step(0, 0, 8,1, 0,0, 3'b011,3'b001, 8,8,0, pk(2,0,1,1,0), pk(2,0,1,1,0));
    step(0, 0, 0,0, 0,0, 3'b000,3'b000, 0,0,0, z, pk(0,0,1,1,0));
    // Reset asserted during FREEZE.
    step(0, 1, 0,0, 0,0, 3'b000,3'b000, 0,0,0, pk(0,0,0,0,1), pk(0,0,0,0,1));
    step(0, 1, 0,0, 0,0, 3'b000,3'b000, 0,0,0, pk(0,0,0,0,1), pk(0,0,0,0,1));
    step(1, 1, 0,0, 0,0, 3'b000,3'b000, 0,0,0, z, z);
`ifdef HFU_STATS_EN
    @(negedge clk);
    chk("frz rst lsc1", lsc1, 0); chk("frz rst fzc1", fzc1, 0);
    chk("frz rst lsc2", lsc2, 0); chk("frz rst fzc2", fzc2, 0);
`endif
    step(0, 0, 0,0, 3,1, 3'b001,3'b001, 3,0,0, pk(0,0,1,1,0), pk(0,0,1,1,0));
    step(0, 0, 0,0, 0,0, 3'b000,3'b000, 0,0,0, z, pk(0,0,1,1,0));
    step(0, 1, 0,0, 0,0, 3'b000,3'b000, 0,0,0, pk(0,0,0,0,1), pk(0,0,0,0,1));
    step(0, 0, 0,0, 0,0, 3'b000,3'b000, 0,0,0, z, z);
`ifdef HFU_STATS_EN
    @(negedge clk);
    chk("cnt lsc1", lsc1, 1); chk("cnt fzc1", fzc1, 1);
    chk("cnt lsc2", lsc2, 2); chk("cnt fzc2", fzc2, 1);
`endif
    for (int i = 0; i < 5 && (exp1_q.size() > 0 || exp2_q.size() > 0); i++)
      @(posedge clk);
    chk("drain q1", exp1_q.size(), 0);
    chk("drain q2", exp2_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
